// File: rtl/regfile_wb_queue_pkg.sv
// Shared constants and the queue entry record for the register-file write-back queue.
package regfile_wb_queue_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  // One queued register write; valid marks an occupied slot.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_queue_wb_fifo.sv
// Circular buffer for write-back entries: two pushes (a older than b) and one pop per
// cycle, pointers wrap modulo DEPTH (any DEPTH, not only powers of two). All slots are
// exported flat so the owner can run register-match logic over them.
module regfile_wb_queue_wb_fifo
  import regfile_wb_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_a,
  input  wb_entry_t             entry_a,
  input  logic                  push_b,
  input  wb_entry_t             entry_b,
  input  logic                  pop,
  output wb_entry_t [DEPTH-1:0] entries,
  output logic [PW-1:0]         head_ptr,
  output logic [CW-1:0]         count
);

  wb_entry_t [DEPTH-1:0] mem;
  logic [PW-1:0]         tail_ptr;
  logic                  do_pop;
  logic [1:0]            n_push;
  wb_entry_t             first_entry;

  assign entries     = mem;
  assign do_pop      = pop && (count != '0);
  assign n_push      = {1'b0, push_a} + {1'b0, push_b};
  // A lone b push takes the tail slot; with both, a goes first and b follows.
  assign first_entry = push_a ? entry_a : entry_b;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] ptr, input int n);
    int sum;
    sum = int'(ptr) + n;
    if (sum >= DEPTH) sum = sum - DEPTH;
    return PW'(sum);
  endfunction

  // Slot storage, pointers and occupancy; the pop clears the head's valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem      <= '0;
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (do_pop) begin
        mem[head_ptr].valid <= 1'b0;
        head_ptr            <= wrap_add(head_ptr, 1);
      end
      if (n_push != 2'd0) mem[tail_ptr] <= first_entry;
      if (n_push == 2'd2) mem[wrap_add(tail_ptr, 1)] <= entry_b;
      tail_ptr <= wrap_add(tail_ptr, int'(n_push));
      count    <= CW'(int'(count) + int'(n_push) - (do_pop ? 1 : 0));
    end
  end

`ifndef SYNTHESIS
  assert property (@(posedge clk) disable iff (!rst_n) int'(count) <= DEPTH);
`endif

endmodule

// File: rtl/regfile_wb_queue.sv
// Write-back queue in front of the 32x32 register file. Accepts results from the load
// unit (MEM) and the ALU, retires one register write per cycle in arrival order, and
// reports which source registers still have writes in flight.
// Data and register-address widths come from regfile_wb_queue_pkg (XLEN, REG_AW).
// Optional: define WB_FWD_EN to add bypass data from the youngest matching entry.
module regfile_wb_queue
  import regfile_wb_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [XLEN-1:0]   mem_data,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_rd_add,
  output logic [XLEN-1:0]   rf_wr_data,
  input  logic [REG_AW-1:0] q_rs1,
  input  logic [REG_AW-1:0] q_rs2,
  output logic              pend_rs1,
  output logic              pend_rs2,
  output logic              fwd1_hit,
  output logic              fwd2_hit,
  output logic [XLEN-1:0]   fwd1_data,
  output logic [XLEN-1:0]   fwd2_data,
  output logic [CW-1:0]     count,
  output logic              empty,
  output logic              full
);

  wb_entry_t [DEPTH-1:0] entries;
  logic [PW-1:0]         head_ptr;
  logic                  push_a;
  logic                  push_b;
  wb_entry_t             entry_a;
  wb_entry_t             entry_b;

  // Handshake: a transfer happens on a rising edge when valid && ready; the producer
  // holds rd/data stable while valid && !ready. Ready depends only on count, never on
  // valid or on the same-cycle pop, and leaves room for both producers at once.
  assign mem_ready = (int'(count) <= DEPTH - 1);
  assign alu_ready = (int'(count) <= DEPTH - 2);

  // Writes to x0 complete the handshake but never occupy a slot.
  assign push_a  = mem_valid && mem_ready && (mem_rd != REG_ZERO);
  assign push_b  = alu_valid && alu_ready && (alu_rd != REG_ZERO);
  assign entry_a = '{valid: 1'b1, rd: mem_rd, data: mem_data};
  assign entry_b = '{valid: 1'b1, rd: alu_rd, data: alu_data};

  assign empty = (count == '0);
  assign full  = (int'(count) == DEPTH);

  // The register file never stalls, so the head retires every cycle it exists.
  assign rf_we      = !empty;
  assign rf_rd_add  = entries[head_ptr].rd;
  assign rf_wr_data = entries[head_ptr].data;

  regfile_wb_queue_wb_fifo #(.DEPTH(DEPTH)) u_wb_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_a   (push_a),
    .entry_a  (entry_a),
    .push_b   (push_b),
    .entry_b  (entry_b),
    .pop      (rf_we),
    .entries  (entries),
    .head_ptr (head_ptr),
    .count    (count)
  );

  // Any occupied slot (including the head being written now) targeting the queried register.
  always_comb begin
    pend_rs1 = 1'b0;
    pend_rs2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entries[i].valid && (entries[i].rd == q_rs1) && (q_rs1 != REG_ZERO)) pend_rs1 = 1'b1;
      if (entries[i].valid && (entries[i].rd == q_rs2) && (q_rs2 != REG_ZERO)) pend_rs2 = 1'b1;
    end
  end

`ifdef WB_FWD_EN
  assign fwd1_hit = pend_rs1;
  assign fwd2_hit = pend_rs2;

  // Walk oldest to youngest so the last match (youngest write) wins.
  always_comb begin
    int idx;
    idx       = 0;
    fwd1_data = '0;
    fwd2_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = int'(head_ptr) + i;
      if (idx >= DEPTH) idx = idx - DEPTH;
      if (entries[PW'(idx)].valid && (entries[PW'(idx)].rd == q_rs1)) fwd1_data = entries[PW'(idx)].data;
      if (entries[PW'(idx)].valid && (entries[PW'(idx)].rd == q_rs2)) fwd2_data = entries[PW'(idx)].data;
    end
  end
`else
  assign fwd1_hit  = 1'b0;
  assign fwd2_hit  = 1'b0;
  assign fwd1_data = '0;
  assign fwd2_data = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Bench for regfile_wb_queue (DEPTH=4). Accepted writes go into exp_q in acceptance
// order; a negedge monitor pops and compares every register-file write.
`timescale 1ns/1ps
module tb_regfile_wb_queue;
  import regfile_wb_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int EW    = REG_AW + XLEN;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              mem_valid = 1'b0;
  logic              mem_ready;
  logic [REG_AW-1:0] mem_rd = '0;
  logic [XLEN-1:0]   mem_data = '0;
  logic              alu_valid = 1'b0;
  logic              alu_ready;
  logic [REG_AW-1:0] alu_rd = '0;
  logic [XLEN-1:0]   alu_data = '0;
  logic              rf_we;
  logic [REG_AW-1:0] rf_rd_add;
  logic [XLEN-1:0]   rf_wr_data;
  logic [REG_AW-1:0] q_rs1 = '0;
  logic [REG_AW-1:0] q_rs2 = '0;
  logic              pend_rs1, pend_rs2;
  logic              fwd1_hit, fwd2_hit;
  logic [XLEN-1:0]   fwd1_data, fwd2_data;
  logic [CW-1:0]     count;
  logic              empty, full;

  int errors = 0;
  int checks = 0;
  logic [EW-1:0] exp_q[$];
  bit mon_en = 1'b0;
  bit popped_now = 1'b0;

  regfile_wb_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .rf_we(rf_we), .rf_rd_add(rf_rd_add), .rf_wr_data(rf_wr_data),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .pend_rs1(pend_rs1), .pend_rs2(pend_rs2),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
    .count(count), .empty(empty), .full(full)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: every write must be the oldest expected entry, and writes must not stall.
  always @(negedge clk) begin
    popped_now = 1'b0;
    if (rst_n && mon_en) begin
      checks++;
      if (rf_we !== (exp_q.size() != 0)) begin
        errors++;
        $display("FAIL drain_we: rf_we=%b expected %b (queued=%0d)", rf_we, exp_q.size() != 0, exp_q.size());
      end
      if (rf_we === 1'b1 && exp_q.size() != 0) begin
        checks++;
        if ({rf_rd_add, rf_wr_data} !== exp_q[0]) begin
          errors++;
          $display("FAIL drain_data: got x%0d=%h expected x%0d=%h", rf_rd_add, rf_wr_data,
                   exp_q[0][EW-1:XLEN], exp_q[0][XLEN-1:0]);
        end
        void'(exp_q.pop_front());
        popped_now = 1'b1;
      end
    end
  end

  // Driver: called just after a rising edge; offers one cycle of stimulus and records transfers.
  task automatic drive_cycle(input logic mv, input logic [REG_AW-1:0] mrd, input logic [XLEN-1:0] md,
                             input logic av, input logic [REG_AW-1:0] ard, input logic [XLEN-1:0] ad,
                             output bit m_acc, output bit a_acc);
    int cur;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    @(negedge clk); #1;
    cur = exp_q.size() + int'(popped_now);
    checks++;
    if (count !== CW'(cur)) begin
      errors++; $display("FAIL count: got %0d expected %0d", count, cur);
    end
    checks++;
    if (mem_ready !== (cur <= DEPTH - 1)) begin
      errors++; $display("FAIL mem_ready: got %b expected %b at count %0d", mem_ready, cur <= DEPTH - 1, cur);
    end
    checks++;
    if (alu_ready !== (cur <= DEPTH - 2)) begin
      errors++; $display("FAIL alu_ready: got %b expected %b at count %0d", alu_ready, cur <= DEPTH - 2, cur);
    end
    checks++;
    if ({full, empty} !== {cur == DEPTH, cur == 0}) begin
      errors++; $display("FAIL full_empty: got %b%b expected %b%b", full, empty, cur == DEPTH, cur == 0);
    end
    m_acc = mv && (cur <= DEPTH - 1);
    a_acc = av && (cur <= DEPTH - 2);
    if (m_acc && mrd != REG_ZERO) exp_q.push_back({mrd, md});
    if (a_acc && ard != REG_ZERO) exp_q.push_back({ard, ad});
    @(posedge clk); #1;
    mem_valid = 1'b0;
    alu_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit ma, aa;
    repeat (n) drive_cycle(1'b0, '0, '0, 1'b0, '0, '0, ma, aa);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rf_we, count, empty, full} !== {1'b0, CW'(0), 1'b1, 1'b0}) begin
      errors++; $display("FAIL reset_state: we=%b count=%0d empty=%b full=%b", rf_we, count, empty, full);
    end
    checks++;
    if ({pend_rs1, pend_rs2, fwd1_hit, fwd2_hit, mem_ready, alu_ready} !== 6'b000011) begin
      errors++; $display("FAIL reset_flags: pend=%b%b fwd=%b%b ready=%b%b expected 000011",
                         pend_rs1, pend_rs2, fwd1_hit, fwd2_hit, mem_ready, alu_ready);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
  endtask

  task automatic test_single_alu();
    bit ma, aa;
    drive_cycle(1'b0, '0, '0, 1'b1, 5'd5, 32'hDEADBEEF, ma, aa);
    checks++;
    if ({rf_we, rf_rd_add, rf_wr_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      errors++; $display("FAIL single_alu: we=%b x%0d=%h expected 1 x5=deadbeef", rf_we, rf_rd_add, rf_wr_data);
    end
    idle(1);
    checks++;
    if ({rf_we, empty} !== 2'b01) begin
      errors++; $display("FAIL single_alu_empty: we=%b empty=%b expected 0 1", rf_we, empty);
    end
  endtask

  task automatic test_same_rd();
    bit ma, aa;
    q_rs1 = 5'd3;
    drive_cycle(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, ma, aa);
    checks++;
    if ({pend_rs1, rf_wr_data} !== {1'b1, 32'h11}) begin
      errors++; $display("FAIL same_rd_first: pend=%b data=%h expected 1 11", pend_rs1, rf_wr_data);
    end
    idle(1);
    checks++;
    if ({pend_rs1, rf_wr_data} !== {1'b1, 32'h22}) begin
      errors++; $display("FAIL same_rd_second: pend=%b data=%h expected 1 22", pend_rs1, rf_wr_data);
    end
    idle(1);
    checks++;
    if ({pend_rs1, empty} !== 2'b01) begin
      errors++; $display("FAIL same_rd_after: pend=%b empty=%b expected 0 1", pend_rs1, empty);
    end
  endtask

  task automatic test_forward();
    bit ma, aa;
    logic exp_hit;
    logic [XLEN-1:0] exp_data;
`ifdef WB_FWD_EN
    exp_hit = 1'b1; exp_data = 32'hB;
`else
    exp_hit = 1'b0; exp_data = '0;
`endif
    q_rs1 = 5'd7;
    q_rs2 = 5'd8;
    drive_cycle(1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB, ma, aa);
    checks++;
    if ({fwd1_hit, fwd1_data} !== {exp_hit, exp_data}) begin
      errors++; $display("FAIL fwd_x7: hit=%b data=%h expected %b %h", fwd1_hit, fwd1_data, exp_hit, exp_data);
    end
    checks++;
    if ({pend_rs2, fwd2_hit} !== 2'b00) begin
      errors++; $display("FAIL fwd_miss: pend2=%b hit2=%b expected 0 0", pend_rs2, fwd2_hit);
    end
    idle(2);
  endtask

  task automatic test_rd_zero();
    bit ma, aa;
    q_rs1 = 5'd0;
    drive_cycle(1'b1, 5'd0, 32'h55, 1'b0, '0, '0, ma, aa);
    checks++;
    if ({ma, count, rf_we, pend_rs1} !== {1'b1, CW'(0), 1'b0, 1'b0}) begin
      errors++; $display("FAIL rd_zero: acc=%b count=%0d we=%b pend=%b expected 1 0 0 0", ma, count, rf_we, pend_rs1);
    end
    drive_cycle(1'b1, 5'd9, 32'h99, 1'b1, 5'd0, 32'h77, ma, aa);
    checks++;
    if ({count, rf_rd_add} !== {CW'(1), 5'd9}) begin
      errors++; $display("FAIL rd_zero_mixed: count=%0d rd=x%0d expected 1 x9", count, rf_rd_add);
    end
    idle(1);
  endtask

  task automatic test_fill();
    bit ma, aa;
    logic [REG_AW-1:0] m_rd, a_rd;
    logic [XLEN-1:0] m_d, a_d;
    logic exp_pend;
    logic [XLEN-1:0] exp_fwd;
    m_rd = REG_AW'($urandom_range(1, 7)); m_d = $urandom;
    a_rd = REG_AW'($urandom_range(1, 7)); a_d = $urandom;
    for (int c = 0; c < 16; c++) begin
      drive_cycle(1'b1, m_rd, m_d, 1'b1, a_rd, a_d, ma, aa);
      if (ma) begin m_rd = REG_AW'($urandom_range(1, 7)); m_d = $urandom; end
      if (aa) begin a_rd = REG_AW'($urandom_range(1, 7)); a_d = $urandom; end
      q_rs2 = REG_AW'($urandom_range(0, 7));
      #1;
      exp_pend = 1'b0;
      exp_fwd = '0;
      foreach (exp_q[i]) begin
        if (exp_q[i][EW-1:XLEN] == q_rs2 && q_rs2 != REG_ZERO) begin
          exp_pend = 1'b1;
          exp_fwd = exp_q[i][XLEN-1:0];
        end
      end
      checks++;
      if (pend_rs2 !== exp_pend) begin
        errors++; $display("FAIL fill_pend: q=x%0d pend=%b expected %b", q_rs2, pend_rs2, exp_pend);
      end
`ifdef WB_FWD_EN
      checks++;
      if ({fwd2_hit, fwd2_data} !== {exp_pend, exp_fwd}) begin
        errors++; $display("FAIL fill_fwd: q=x%0d hit=%b data=%h expected %b %h", q_rs2, fwd2_hit, fwd2_data, exp_pend, exp_fwd);
      end
`endif
    end
    for (int w = 0; w < 20 && exp_q.size() != 0; w++) idle(1);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL fill_drain: %0d entries never retired", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ma, aa;
    drive_cycle(1'b1, 5'd10, 32'h100, 1'b1, 5'd11, 32'h101, ma, aa);
    drive_cycle(1'b1, 5'd12, 32'h102, 1'b1, 5'd13, 32'h103, ma, aa);
    q_rs1 = 5'd12;
    q_rs2 = 5'd13;
    #1;
    checks++;
    if ({count, pend_rs1, pend_rs2} !== {CW'(3), 1'b1, 1'b1}) begin
      errors++; $display("FAIL mid_prefill: count=%0d pend=%b%b expected 3 11", count, pend_rs1, pend_rs2);
    end
    rst_n = 1'b0;
    mon_en = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if ({rf_we, count, empty, pend_rs1, pend_rs2} !== {1'b0, CW'(0), 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL mid_reset: we=%b count=%0d empty=%b pend=%b%b expected 0 0 1 00",
                         rf_we, count, empty, pend_rs1, pend_rs2);
    end
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    idle(3);
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_same_rd();
    test_forward();
    test_rd_zero();
    test_fill();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
